// File: rtl/spi_arbiter.sv
// Two-requester round-robin front end for a single SPI shift engine.
// Grants one transfer at a time and reports completion or timeout.
module spi_arbiter #(
    parameter int SIZE    = 8,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0,
    input  logic            req1,
    input  logic [SIZE-1:0] wdata0,
    input  logic [SIZE-1:0] wdata1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            done0,
    output logic            done1,
    output logic            err0,
    output logic            err1,
    output logic [SIZE-1:0] rdata,
    output logic            busy,
    output logic            spi_start,
    output logic [SIZE-1:0] spi_tx,
    input  logic            spi_done,
    input  logic [SIZE-1:0] spi_rx
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 2);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } state_t;

    state_t        state;
    logic          ptr;
    logic          cur;
    logic [CW-1:0] cnt;
    logic          win1;

    // ptr holds the last winner; requester 1 wins only if alone or 0 won last
    assign win1 = req1 && (!req0 || !ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 1'b1;
            cur       <= 1'b0;
            cnt       <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            spi_start <= 1'b0;
            busy      <= 1'b0;
            spi_tx    <= '0;
            rdata     <= '0;
        end else begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            spi_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        cur       <= win1;
                        gnt0      <= !win1;
                        gnt1      <= win1;
                        spi_tx    <= win1 ? wdata1 : wdata0;
                        spi_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (spi_done) begin
                        rdata <= spi_rx;
                        done0 <= !cur;
                        done1 <= cur;
                        ptr   <= cur;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == LAST) begin
                        err0  <= !cur;
                        err1  <= cur;
                        ptr   <= cur;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed self-checking bench for spi_arbiter.
// The bench plays the SPI engine role by hand.
module tb_spi_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, done0, done1, err0, err1;
    logic [7:0] rdata;
    logic       busy, spi_start;
    logic [7:0] spi_tx;
    logic       spi_done;
    logic [7:0] spi_rx;

    int tests = 0;
    int fails = 0;
    int g0cnt = 0;

    spi_arbiter #(.SIZE(8), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1),
        .err0(err0), .err1(err1),
        .rdata(rdata), .busy(busy),
        .spi_start(spi_start), .spi_tx(spi_tx),
        .spi_done(spi_done), .spi_rx(spi_rx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("onehot_pulses",
                32'($countones({gnt0, gnt1, done0, done1, err0, err1}) <= 1),
                32'd1);
            if (gnt0) g0cnt++;
        end
    end

    initial begin
        rst_n = 1'b0;
        req0 = 0; req1 = 0;
        wdata0 = '0; wdata1 = '0;
        spi_done = 0; spi_rx = '0;
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {gnt0, gnt1, done0, done1, err0, err1, spi_start}, 0);
        chk("rst_spi_tx", spi_tx, 0);
        chk("rst_rdata", rdata, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_gnt", {gnt0, gnt1}, 0);

        // single transfer, engine answers 4 cycles after start
        req0 = 1; wdata0 = 8'h53;
        tick();
        chk("t1_gnt0", gnt0, 1);
        chk("t1_start", spi_start, 1);
        chk("t1_spi_tx", spi_tx, 8'h53);
        chk("t1_busy", busy, 1);
        req0 = 0;
        tick();
        chk("t1_gnt0_once", gnt0, 0);
        chk("t1_start_once", spi_start, 0);
        repeat (3) tick();
        chk("t1_tx_stable", spi_tx, 8'h53);
        spi_done = 1; spi_rx = 8'h9A;
        tick();
        spi_done = 0;
        chk("t1_done0", done0, 1);
        chk("t1_rdata", rdata, 8'h9A);
        chk("t1_busy_low", busy, 0);
        tick();
        chk("t1_done0_once", done0, 0);

        // simultaneous requests from reset alternate 0,1,0,1
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
        req0 = 1; req1 = 1; wdata0 = 8'hA0; wdata1 = 8'hB1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("rr_gnt0", gnt0, (i % 2 == 0) ? 1 : 0);
            chk("rr_gnt1", gnt1, (i % 2 == 1) ? 1 : 0);
            chk("rr_spi_tx", spi_tx, (i % 2 == 1) ? 8'hB1 : 8'hA0);
            tick();
            spi_done = 1; spi_rx = 8'(8'h10 + i);
            if (i == 3) begin
                req0 = 0; req1 = 0;
            end
            tick();
            spi_done = 0;
            chk("rr_done0", done0, (i % 2 == 0) ? 1 : 0);
            chk("rr_done1", done1, (i % 2 == 1) ? 1 : 0);
            chk("rr_rdata", rdata, 8'h10 + i);
            if (i < 3) tick();
        end
        tick();
        chk("rr_idle_busy", busy, 0);
        chk("rr_no_gnt", {gnt0, gnt1}, 0);

        // only requester 1, three back-to-back transfers
        g0cnt = 0;
        req1 = 1; wdata1 = 8'hC3;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("solo_gnt1", gnt1, 1);
            tick();
            spi_done = 1; spi_rx = 8'(8'h20 + i);
            if (i == 2) req1 = 0;
            tick();
            spi_done = 0;
            chk("solo_done1", done1, 1);
            if (i < 2) tick();
        end
        tick();
        chk("solo_no_gnt0", g0cnt, 0);

        // timeout: err 64 cycles after start, pending req1 then served
        req0 = 1; wdata0 = 8'h77;
        tick();
        chk("to_gnt0", gnt0, 1);
        req0 = 0; req1 = 1; wdata1 = 8'h88;
        repeat (63) tick();
        chk("to_err_early", err0, 0);
        chk("to_busy_wait", busy, 1);
        tick();
        chk("to_err0", err0, 1);
        chk("to_done0", done0, 0);
        chk("to_rdata_kept", rdata, 8'h22);
        chk("to_busy_low", busy, 0);
        tick();
        chk("to_next_gnt1", gnt1, 1);
        chk("to_next_tx", spi_tx, 8'h88);
        req1 = 0;
        tick();
        spi_done = 1; spi_rx = 8'h5A;
        tick();
        spi_done = 0;
        chk("to_next_done1", done1, 1);
        chk("to_next_rdata", rdata, 8'h5A);
        tick();

        // spi_done on the timeout edge wins over err
        req0 = 1; wdata0 = 8'h44;
        tick();
        req0 = 0;
        repeat (63) tick();
        spi_done = 1; spi_rx = 8'h66;
        tick();
        spi_done = 0;
        chk("tie_done0", done0, 1);
        chk("tie_err0", err0, 0);
        chk("tie_rdata", rdata, 8'h66);
        tick();

        // reset during WAIT, late spi_done ignored
        req0 = 1; wdata0 = 8'h99;
        tick();
        req0 = 0;
        repeat (3) tick();
        rst_n = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_spi_tx", spi_tx, 0);
        chk("arst_rdata", rdata, 0);
        chk("arst_pulses", {gnt0, gnt1, done0, done1, err0, err1, spi_start}, 0);
        tick();
        rst_n = 1;
        spi_done = 1; spi_rx = 8'hEE;
        tick();
        spi_done = 0;
        for (int i = 0; i < 3; i++) begin
            chk("late_pulses", {gnt0, gnt1, done0, done1, err0, err1, spi_start}, 0);
            chk("late_busy", busy, 0);
            chk("late_rdata", rdata, 0);
            tick();
        end

        // spi_done while idle leaves rdata alone
        req1 = 1; wdata1 = 8'h12;
        tick();
        chk("idle_gnt1", gnt1, 1);
        req1 = 0;
        tick();
        spi_done = 1; spi_rx = 8'h3C;
        tick();
        spi_done = 0;
        chk("idle_pre_done1", done1, 1);
        chk("idle_pre_rdata", rdata, 8'h3C);
        tick();
        spi_done = 1; spi_rx = 8'hFF;
        tick();
        spi_done = 0;
        chk("idle_sd_rdata", rdata, 8'h3C);
        chk("idle_sd_done", {done0, done1}, 0);
        chk("idle_sd_busy", busy, 0);
        tick();
        chk("idle_sd_rdata2", rdata, 8'h3C);
        chk("idle_sd_done2", {done0, done1}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter: SIZE, 8, transfer width in bits.
REQ-002 Parameter: TIMEOUT, 64, maximum clk cycles in WAIT before abort; TIMEOUT >= 2.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0 / req1  input  1 each  transfer request from requester 0 / 1; held high until the matching gnt pulse.
REQ-006 wdata0 / wdata1  input  SIZE each  transmit byte of requester 0 / 1; valid while the matching req is high.
REQ-007 gnt0 / gnt1  output  1 each  one-cycle pulse: request accepted, wdata captured.
REQ-008 done0 / done1  output  1 each  one-cycle pulse: transfer completed, rdata valid.
REQ-009 err0 / err1  output  1 each  one-cycle pulse: transfer aborted by timeout.
REQ-010 rdata  output  SIZE  last received byte; shared by both requesters and held until the next successful completion.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 spi_start  output  1  one-cycle start strobe to the SPI engine.
REQ-013 spi_tx  output  SIZE  byte to shift out; stable from spi_start until return to IDLE.
REQ-014 spi_done  input  1  one-cycle pulse from the SPI engine: shift complete.
REQ-015 spi_rx  input  SIZE  received byte; valid in the spi_done cycle.

Function
REQ-016 FSM states: IDLE, START, WAIT; all outputs registered.
REQ-017 IDLE, no req high: remain IDLE; no outputs pulse.
REQ-018 IDLE, any req high at an edge: select winner, capture its wdata into spi_tx, pulse that gnt in the next cycle, go to START.
REQ-019 Arbitration is round-robin: when both reqs are high, the requester that did not win last wins; with a single req, that requester wins regardless of history.
REQ-020 Last-winner pointer resets to 1, so requester 0 wins the first simultaneous contention.
REQ-021 START: spi_start high for exactly this one cycle (coincident with the gnt pulse); then go to WAIT and clear the timeout counter.
REQ-022 WAIT, spi_done high: capture spi_rx into rdata, pulse the winner's done in the next cycle, update the pointer, go to IDLE.
REQ-023 WAIT, no spi_done: increment the counter; when it reaches TIMEOUT-1, pulse the winner's err in the next cycle, leave rdata unchanged, update the pointer, go to IDLE.
REQ-024 If spi_done and the timeout occur in the same cycle, spi_done wins: done is pulsed, not err.
REQ-025 spi_done outside WAIT is ignored.
REQ-026 The FSM accepts a new request in the cycle its done or err pulse is high, so the earliest next gnt is one cycle after done.
REQ-027 req changes after gnt have no effect on the current transfer; a req still high after done is a new request.
REQ-028 At most one of gnt0, gnt1, done0, done1, err0, err1 is high in any cycle.
REQ-029 Latency: req sampled at edge N -> gnt and spi_start high in cycle N+1; spi_done sampled at edge M -> done high in cycle M+1.

Reset
REQ-030 rst_n low asynchronously forces: state IDLE, pointer = 1, counter = 0, and all of gnt*, done*, err*, spi_start, busy, spi_tx, rdata = 0.
REQ-031 Reset mid-transfer aborts it with no done or err pulse; after rst_n rises, a late spi_done is ignored.

Verification
REQ-032 req0 high with wdata0=8'h53; engine returns spi_done with spi_rx=8'h9A four cycles after spi_start -> gnt0 one pulse, spi_tx=8'h53, done0 one pulse, rdata=8'h9A, busy low afterwards.
REQ-033 req0 and req1 high together from reset, held high -> grant order 0,1,0,1; each gnt follows the previous done by exactly one cycle.
REQ-034 Only req1 repeatedly, 3 transfers -> gnt1 each time; gnt0 never asserts.
REQ-035 Engine never returns spi_done, TIMEOUT=64 -> err pulse 64 cycles after spi_start; rdata unchanged; the next request is granted to the other requester if it is pending.
REQ-036 rst_n low during WAIT, then spi_done arrives after release -> all outputs 0, no done or err, FSM stays IDLE.
REQ-037 spi_done pulsed while IDLE -> rdata unchanged, no done pulse.
